// File: rtl/cube_share_sched_pkg.sv
// rtl/cube_share_sched_pkg.sv - shared types and helpers for the cube scheduler
package cube_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int CUBE_WIDTH = 32;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cube_share_sched_if.sv
// rtl/cube_share_sched_if.sv - requester, response and datapath signals of the cube scheduler
interface cube_share_sched_if
   import cube_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = CUBE_WIDTH
) ();

   localparam int ID_W = id_width(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_x;
   logic [NREQ-1:0]       req_ready;
   logic                  resp_valid;
   logic [ID_W-1:0]       resp_id;
   logic [WIDTH-1:0]      resp_data;
   logic                  resp_ready;
   logic [WIDTH-1:0]      dp_x;
   logic                  dp_en;
   logic [WIDTH-1:0]      dp_out;
   logic                  busy;

   modport master (
      output req_valid, req_x, resp_ready, dp_out,
      input  req_ready, resp_valid, resp_id, resp_data, dp_x, dp_en, busy
   );

   modport slave (
      input  req_valid, req_x, resp_ready, dp_out,
      output req_ready, resp_valid, resp_id, resp_data, dp_x, dp_en, busy
   );

endinterface

// File: rtl/cube_share_sched_rr_pick.sv
// rtl/cube_share_sched_rr_pick.sv - combinational rotate-priority picker
module rr_pick
   import cube_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = id_width(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] index,
   output logic            any
);

   always_comb begin
      int j;
      grant = '0;
      index = '0;
      j     = 0;
      any   = |valid;
      // walk from the farthest slot back to ptr so the closest valid one wins
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % NREQ;
         if (valid[j]) begin
            index = ID_W'(j);
         end
      end
      if (any) begin
         grant[index] = 1'b1;
      end
   end

endmodule

// File: rtl/cube_share_sched.sv
// rtl/cube_share_sched.sv - round-robin sharing of one external cube datapath among NREQ requesters
module cube_share_sched
   import cube_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = CUBE_WIDTH,
   parameter int LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst,
   cube_share_sched_if.slave bus
);

   localparam int ID_W  = id_width(NREQ);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   generate
      if (NREQ < 2 || NREQ > 16 || LATENCY < 1) begin : g_bad_cfg
         $error("cube_share_sched: NREQ must be 2..16 and LATENCY >= 1");
      end
   endgenerate

   state_t           state;
   state_t           state_nx;
   logic             accept;
   logic [NREQ-1:0]  pick_grant;
   logic [ID_W-1:0]  pick_idx;
   logic             pick_any;
   logic [WIDTH-1:0] pick_x;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  id_reg;
   logic [CNT_W-1:0] cnt;

   rr_pick #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_pick (
      .valid (bus.req_valid),
      .ptr   (ptr),
      .grant (pick_grant),
      .index (pick_idx),
      .any   (pick_any)
   );

   assign pick_x        = bus.req_x[int'(pick_idx)*WIDTH +: WIDTH];
   assign bus.req_ready = (state == IDLE && !rst) ? pick_grant : '0;
   assign bus.busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any && !rst) begin
               accept   = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: state_nx = WAIT;
         WAIT: begin
            if (cnt == '0) begin
               state_nx = RESP;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // dp_x doubles as the operand register: loaded on accept, held until the next accept
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr            <= '0;
         id_reg         <= '0;
         cnt            <= '0;
         bus.dp_en      <= 1'b0;
         bus.dp_x       <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_id    <= '0;
         bus.resp_data  <= '0;
      end else begin
         bus.dp_en <= accept;
         if (accept) begin
            bus.dp_x <= pick_x;
            id_reg   <= pick_idx;
            ptr      <= (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + ID_W'(1);
         end
         if (state == ISSUE) begin
            cnt <= CNT_W'(LATENCY - 1);
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (state == WAIT && cnt == '0) begin
            bus.resp_data  <= bus.dp_out;
            bus.resp_id    <= id_reg;
            bus.resp_valid <= 1'b1;
         end else if (state == RESP && bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cube_share_sched.sv
// tb/tb_cube_share_sched.sv - self-checking bench for cube_share_sched with a cycle-level reference model
module tb_cube_share_sched;
   import cube_sched_pkg::*;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 32;
   localparam int LATENCY = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cube_share_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   cube_share_sched #(
      .NREQ    (NREQ),
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] cube_ref(input logic [31:0] x);
      longint unsigned a;
      a = longint'(x);
      a = (a * a) & 64'hFFFF_FFFF;
      a = (a * longint'(x)) & 64'hFFFF_FFFF;
      return a[31:0];
   endfunction

   // stand-in for the external two-stage datapath; garbage whenever no result is due
   logic [31:0] p1_x;
   logic        p1_v;
   always_ff @(posedge clk) begin
      p1_x       <= bus.dp_x;
      p1_v       <= bus.dp_en;
      bus.dp_out <= p1_v ? cube_ref(p1_x) : 32'($urandom());
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int          cyc;
   bit          m_busy;
   int          m_acc;
   int          m_id;
   int          m_ptr;
   logic [31:0] m_x;
   int          last_gnt;
   int          hs_cyc;
   int          gnt_log[$];
   logic [31:0] res_log[$];

   function automatic int rr_ref(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // called at a negedge with inputs already driven; checks, updates the model, advances one cycle
   task automatic step();
      int              g;
      logic [NREQ-1:0] exp_rdy;
      bit              exp_rv;
      bit              exp_en;
      #1;
      g       = (rst || m_busy) ? -1 : rr_ref(bus.req_valid, m_ptr);
      exp_rdy = (g < 0) ? '0 : (NREQ'(1) << g);
      exp_rv  = m_busy && (cyc >= m_acc + 1 + LATENCY);
      exp_en  = m_busy && (cyc == m_acc);
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("busy", bus.busy, m_busy);
      chk("resp_valid", bus.resp_valid, exp_rv);
      chk("dp_en", bus.dp_en, exp_en);
      if (m_busy) chk("dp_x", bus.dp_x, m_x);
      if (exp_rv) begin
         chk("resp_id", bus.resp_id, m_id);
         chk("resp_data", bus.resp_data, cube_ref(m_x));
      end
      last_gnt = -1;
      if (rst) begin
         m_busy = 1'b0;
         m_ptr  = 0;
      end else if (g >= 0) begin
         m_busy   = 1'b1;
         m_acc    = cyc + 1;
         m_id     = g;
         m_x      = bus.req_x[g*WIDTH +: WIDTH];
         m_ptr    = (g + 1) % NREQ;
         last_gnt = g;
         gnt_log.push_back(g);
      end else if (exp_rv && bus.resp_ready) begin
         m_busy = 1'b0;
         res_log.push_back(bus.resp_data);
         hs_cyc = cyc + 1;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input bit v, input logic [31:0] x);
      bus.req_valid[i] = v;
      if (v) bus.req_x[i*WIDTH +: WIDTH] = x;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_grant(input int id);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (last_gnt < 0 && n < 20);
      chk("grant_id", 64'(last_gnt), 64'(id));
   endtask

   task automatic single_op(input int id, input logic [31:0] x, input logic [31:0] exp);
      int n0;
      int k;
      set_req(id, 1'b1, x);
      bus.resp_ready = 1'b1;
      wait_grant(id);
      set_req(id, 1'b0, '0);
      n0 = res_log.size();
      k  = 0;
      while (res_log.size() == n0 && k < 20) begin
         step();
         k++;
      end
      if (res_log.size() == n0) chk("resp_timeout", 0, 1);
      else                      chk("cube_value", res_log[$], exp);
   endtask

   initial begin
      int k;
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_x     = '0;
      bus.resp_ready = 1'b0;
      cyc = 0; m_busy = 1'b0; m_ptr = 0; m_acc = 0; m_id = 0; m_x = '0;
      last_gnt = -1; hs_cyc = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_dp_en", bus.dp_en, 0);
      chk("rst_dp_x", bus.dp_x, 0);
      chk("rst_resp_id", bus.resp_id, 0);
      chk("rst_resp_data", bus.resp_data, 0);
      bus.req_valid = 4'b0101;
      #1;
      chk("rst_req_ready", bus.req_ready, 0);
      bus.req_valid = '0;
      rst = 1'b0;

      // single request and wrap-around values
      single_op(0, 32'd2, 32'd8);
      single_op(1, 32'd3, 32'd27);
      single_op(2, 32'h0001_0000, 32'd0);
      single_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      single_op(0, 32'd0, 32'd0);

      // round-robin with all requesters continuously valid
      do_reset();
      gnt_log.delete();
      res_log.delete();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'(i + 1));
      bus.resp_ready = 1'b1;
      repeat (26) step();
      bus.req_valid = '0;
      repeat (8) step();
      if (gnt_log.size() < 5) chk("rr_grant_count", gnt_log.size(), 5);
      else for (int i = 0; i < 5; i++) chk("rr_order", gnt_log[i], i % NREQ);
      if (res_log.size() < 4) chk("rr_result_count", res_log.size(), 4);
      else for (int i = 0; i < 4; i++) chk("rr_result", res_log[i], cube_ref(32'(i + 1)));

      // backpressure: result held, no accept, re-accept one cycle after the handshake
      bus.resp_ready = 1'b0;
      set_req(1, 1'b1, 32'd5);
      wait_grant(1);
      set_req(1, 1'b0, '0);
      k = 0;
      while (!(m_busy && cyc >= m_acc + 1 + LATENCY) && k < 10) begin
         step();
         k++;
      end
      set_req(2, 1'b1, 32'd6);
      repeat (5) step();
      bus.resp_ready = 1'b1;
      step();
      step();
      chk("reaccept_grant", 64'(last_gnt), 2);
      chk("reaccept_gap", 64'(m_acc - hs_cyc), 1);
      set_req(2, 1'b0, '0);
      repeat (8) step();

      // reset while waiting on the datapath
      set_req(1, 1'b1, 32'd9);
      wait_grant(1);
      set_req(1, 1'b0, '0);
      step();
      step();
      do_reset();
      step();
      single_op(2, 32'd7, 32'd343);

      // sparse request set after the pointer has moved past 0
      do_reset();
      single_op(0, 32'd4, 32'd64);
      gnt_log.delete();
      set_req(3, 1'b1, 32'd10);
      set_req(0, 1'b1, 32'd11);
      k = 0;
      while (gnt_log.size() < 2 && k < 30) begin
         step();
         if (last_gnt >= 0) set_req(last_gnt, 1'b0, '0);
         k++;
      end
      if (gnt_log.size() < 2) chk("sparse_count", gnt_log.size(), 2);
      else begin
         chk("sparse_first", gnt_log[0], 3);
         chk("sparse_second", gnt_log[1], 0);
      end
      repeat (8) step();

      // randomized traffic, backpressure and occasional resets
      repeat (600) begin
         if (last_gnt >= 0 && $urandom_range(1, 0) == 1) set_req(last_gnt, 1'b0, '0);
         for (int i = 0; i < NREQ; i++) begin
            if (!bus.req_valid[i] && $urandom_range(3, 0) == 0)
               set_req(i, 1'b1, ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15, 0))
                                                            : 32'($urandom()));
            else if (bus.req_valid[i] && $urandom_range(15, 0) == 0)
               set_req(i, 1'b0, '0);
         end
         bus.resp_ready = ($urandom_range(2, 0) != 0);
         rst = ($urandom_range(99, 0) == 0);
         step();
      end
      rst = 1'b0;
      bus.req_valid = '0;
      bus.resp_ready = 1'b1;
      repeat (8) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cube_share_sched.md
Name: cube_share_sched

Overview:
Round-robin scheduler that shares one 32-bit cube datapath (out = x*x*x mod 2^32, non_inlined_32) among N requesters. Requesters use valid/ready handshakes.
- Accept one request at a time.
- Drive the datapath's x/en pins for one issue cycle.
- Wait the fixed datapath latency, capture the result and return it tagged with the requester id.
- Sits between request-generating logic and a single datapath instance, which is instantiated outside this block.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 32, operand/result width
LATENCY, 2, rising edges from the edge that samples dp_en=1 until dp_out is valid (dp_out valid in the cycle after the LATENCY-th edge)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_x  in  NREQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH]; held stable while req_valid[i]
req_ready  out  NREQ  one-hot grant/accept; at most one bit set
resp_valid  out  1  result available
resp_id  out  clog2(NREQ)  requester that owns resp_data
resp_data  out  WIDTH  cube result
resp_ready  in  1  consumer accepts result
dp_x  out  WIDTH  operand to datapath (registered)
dp_en  out  1  datapath enable (registered)
dp_out  in  WIDTH  datapath result
busy  out  1  state != IDLE

Behaviour:
- Reset (rst high at an edge, including mid-operation):
  - state=IDLE, rr pointer=0.
  - dp_en=0, dp_x=0, resp_valid=0, resp_id=0, resp_data=0.
  - req_ready=0 while rst is high.
  - Any in-flight operation is dropped.
- IDLE:
  - g = first i with req_valid[i], searching ptr, ptr+1, ... mod NREQ.
  - req_ready[g]=1 combinationally only if any valid and rst=0; all other bits are 0.
  - At the accept edge: x_reg<=req_x[g], id_reg<=g, ptr<=(g+1) mod NREQ, state<=ISSUE.
  - No valid: stay in IDLE with ptr unchanged.
- ISSUE: lasts 1 cycle.
  - dp_en=1, dp_x=x_reg.
  - Next state WAIT, cnt<=LATENCY-1.
- WAIT: lasts LATENCY cycles.
  - dp_en=0; dp_x holds x_reg.
  - Each cycle cnt decrements.
  - In the cycle with cnt==0, at that edge resp_data<=dp_out, resp_id<=id_reg, resp_valid<=1, state<=RESP.
- RESP:
  - resp_valid=1 with data/id stable until the edge where resp_ready=1.
  - At that edge: resp_valid<=0, state<=IDLE.
  - No new request is accepted in that same cycle; the earliest next accept is the following cycle.
- Latency from accept edge A:
  - resp_valid rises after edge A+1+LATENCY (A+3 at default).
  - Minimum period per operation is LATENCY+3 cycles.
- Arithmetic: wrap modulo 2^WIDTH, computed entirely by the datapath. The scheduler never alters data.
- Fairness:
  - A requester that stays valid is served within NREQ grants.
  - A requester that drops valid while not granted is simply skipped.
  - Dropping valid after accept has no effect on the operation in flight.
- Simultaneous events:
  - Requests arriving in non-IDLE states wait; req_ready stays 0.
  - resp_ready while resp_valid=0 is ignored.
- Illegal: NREQ<2 or LATENCY<1. Flag with an elaboration-time error.

Decomposition:
- Shared package cube_sched_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP} (2-bit encoding)
  - localparam CUBE_WIDTH=32
  - helper function for id width (clog2)
- One sub-module, rr_pick:
  - Inputs: NREQ-bit valid vector, pointer.
  - Outputs: one-hot grant and binary index.
  - Purely combinational, rotate-priority.
- Datapath is not instantiated inside; the bench connects non_inlined_32 to dp_x/dp_en/dp_out/clk.

Test Plan:
- Single request, NREQ=4, LATENCY=2: req_valid=4'b0001, x=2 -> req_ready[0] high one cycle; dp_en high exactly 1 cycle with dp_x=2; resp_valid rises 3 edges after accept; resp_data=8, resp_id=0.
- Wrap-around values: x=3 -> 27; x=32'h0001_0000 -> 0; x=32'hFFFF_FFFF -> 32'hFFFF_FFFF; x=0 -> 0.
- Round-robin: all four valid continuously with x=i+1, resp_ready=1 -> grant order 0,1,2,3,0; results 1,8,27,64; no requester served twice before others.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_data/resp_id stable, req_ready stays 0; release -> next accept occurs exactly one cycle after the resp handshake edge.
- Reset mid-operation: assert rst during WAIT -> next cycle busy=0, resp_valid=0, dp_en=0, ptr=0; a new request from requester 2 is then granted and returns the correct cube.
- Sparse/skip: ptr=1 after serving 0, only req_valid[3] and req_valid[0] high -> requester 3 granted first, then 0.
